// File: rtl/card_game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | card_game_pkg : shared result codes, controller states, card width   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package card_game_pkg;

  localparam int DEFAULT_CARD_W = 4;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_DRAW = 2'b01;
  localparam logic [1:0] RES_P1   = 2'b10;
  localparam logic [1:0] RES_P2   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_COMPARE   = 3'd2,
    ST_CHECK     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  // A comparator that reports nothing is scored as a draw.
  function automatic logic [1:0] norm_result(input logic [1:0] r);
    return (r == RES_NONE) ? RES_DRAW : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | round_controller_if : player handshakes, comparator link, game status|
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
interface round_controller_if
  import card_game_pkg::*;
#(
  parameter int CARD_W  = DEFAULT_CARD_W,
  parameter int SCORE_W = 4
) ();

  logic               start;
  logic               p1_card_valid;
  logic [CARD_W-1:0]  p1_card;
  logic               p1_card_ready;
  logic               p2_card_valid;
  logic [CARD_W-1:0]  p2_card;
  logic               p2_card_ready;
  logic [CARD_W-1:0]  cmp_p1_card;
  logic [CARD_W-1:0]  cmp_p2_card;
  logic [1:0]         cmp_result;
  logic [1:0]         round_result;
  logic               round_result_valid;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [SCORE_W-1:0] round_idx;
  logic               busy;
  logic               game_over;
  logic [1:0]         game_winner;

  modport master (
    input  start, p1_card_valid, p1_card, p2_card_valid, p2_card, cmp_result,
    output p1_card_ready, p2_card_ready, cmp_p1_card, cmp_p2_card,
           round_result, round_result_valid, p1_score, p2_score, round_idx,
           busy, game_over, game_winner
  );

  modport slave (
    output start, p1_card_valid, p1_card, p2_card_valid, p2_card, cmp_result,
    input  p1_card_ready, p2_card_ready, cmp_p1_card, cmp_p2_card,
           round_result, round_result_valid, p1_score, p2_score, round_idx,
           busy, game_over, game_winner
  );

endinterface
`default_nettype wire

// File: rtl/card_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | card_slot : valid/ready card capture with latched flag and clear     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module card_slot
  import card_game_pkg::*;
#(
  parameter int CARD_W = DEFAULT_CARD_W
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              i_enable,
  input  wire logic              i_clear,
  input  wire logic              i_valid,
  input  wire logic [CARD_W-1:0] i_card,
  output      logic              o_ready,
  output      logic              o_accept,
  output      logic              o_latched,
  output      logic [CARD_W-1:0] o_card
);

  logic              r_latched;
  logic [CARD_W-1:0] r_card;

  assign o_ready   = i_enable & ~r_latched;
  assign o_accept  = i_valid & o_ready;
  assign o_latched = r_latched;
  assign o_card    = r_card;

  // The card value survives a clear so the comparator operand stays stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_latched <= 1'b0;
      r_card    <= '0;
    end else if (i_clear) begin
      r_latched <= 1'b0;
    end else if (o_accept) begin
      r_latched <= 1'b1;
      r_card    <= i_card;
    end
  end

endmodule
`default_nettype wire

// File: rtl/round_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | round_controller : best-of-N two-player card game sequencer          |
// | Option macro     : ROUND_TIEBREAK_EN (sudden death on level scores)  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module round_controller
  import card_game_pkg::*;
#(
  parameter int CARD_W    = DEFAULT_CARD_W,
  parameter int ROUNDS    = 5,
  parameter int WIN_SCORE = 3,
  parameter int SCORE_W   = 4
) (
  input wire logic          clk,
  input wire logic          reset,
  round_controller_if.master bus
);

  localparam logic [SCORE_W-1:0] C_WIN     = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] C_ROUNDS  = SCORE_W'(ROUNDS);
  localparam logic [SCORE_W-1:0] C_IDX_MAX = '1;

  state_t             r_state;
  state_t             w_state_next;
  logic [SCORE_W-1:0] r_p1_score;
  logic [SCORE_W-1:0] r_p2_score;
  logic [SCORE_W-1:0] r_round_idx;
  logic [1:0]         r_round_result;
  logic               r_round_result_valid;
  logic [1:0]         r_game_winner;

  logic               w_collect;
  logic               w_clear;
  logic               w_busy;
  logic               w_game_over;
  logic               w_p1_ready, w_p1_accept, w_p1_latched;
  logic               w_p2_ready, w_p2_accept, w_p2_latched;
  logic [CARD_W-1:0]  w_p1_card, w_p2_card;
  logic [1:0]         w_result;
  logic [1:0]         w_leader;
  logic               w_regulation_done;
  logic               w_game_end;

  card_slot #(.CARD_W(CARD_W)) u_slot_p1 (
    .clk(clk), .reset(reset), .i_enable(w_collect), .i_clear(w_clear),
    .i_valid(bus.p1_card_valid), .i_card(bus.p1_card),
    .o_ready(w_p1_ready), .o_accept(w_p1_accept),
    .o_latched(w_p1_latched), .o_card(w_p1_card)
  );

  card_slot #(.CARD_W(CARD_W)) u_slot_p2 (
    .clk(clk), .reset(reset), .i_enable(w_collect), .i_clear(w_clear),
    .i_valid(bus.p2_card_valid), .i_card(bus.p2_card),
    .o_ready(w_p2_ready), .o_accept(w_p2_accept),
    .o_latched(w_p2_latched), .o_card(w_p2_card)
  );

  assign w_result = norm_result(bus.cmp_result);
  assign w_leader = (r_p1_score > r_p2_score) ? RES_P1 :
                    (r_p2_score > r_p1_score) ? RES_P2 : RES_DRAW;

`ifdef ROUND_TIEBREAK_EN
  // Level scores after regulation keep the game going until someone leads.
  assign w_regulation_done = (r_round_idx >= C_ROUNDS) && (r_p1_score != r_p2_score);
`else
  assign w_regulation_done = (r_round_idx >= C_ROUNDS);
`endif

  assign w_game_end = (r_p1_score == C_WIN) || (r_p2_score == C_WIN) || w_regulation_done;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_GAME_OVER: if (bus.start) w_state_next = ST_COLLECT;
      ST_COLLECT:
        if ((w_p1_latched || w_p1_accept) && (w_p2_latched || w_p2_accept))
          w_state_next = ST_COMPARE;
      ST_COMPARE: w_state_next = ST_CHECK;
      ST_CHECK:   w_state_next = w_game_end ? ST_GAME_OVER : ST_COLLECT;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_collect   = 1'b0;
    w_clear     = 1'b0;
    w_busy      = 1'b0;
    w_game_over = 1'b0;
    case (r_state)
      ST_COLLECT:   begin w_collect = 1'b1; w_busy = 1'b1; end
      ST_COMPARE:   w_busy = 1'b1;
      ST_CHECK:     begin w_clear = 1'b1; w_busy = 1'b1; end
      ST_GAME_OVER: w_game_over = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1_score           <= '0;
      r_p2_score           <= '0;
      r_round_idx          <= '0;
      r_round_result       <= RES_NONE;
      r_round_result_valid <= 1'b0;
      r_game_winner        <= RES_NONE;
    end else begin
      r_round_result_valid <= (r_state == ST_COMPARE);
      case (r_state)
        ST_IDLE, ST_GAME_OVER: begin
          if (bus.start) begin
            r_p1_score     <= '0;
            r_p2_score     <= '0;
            r_round_idx    <= '0;
            r_round_result <= RES_NONE;
            r_game_winner  <= RES_NONE;
          end
        end
        ST_COMPARE: begin
          r_round_result <= w_result;
          if (w_result == RES_P1 && r_p1_score < C_WIN) r_p1_score <= r_p1_score + 1'b1;
          if (w_result == RES_P2 && r_p2_score < C_WIN) r_p2_score <= r_p2_score + 1'b1;
          if (r_round_idx != C_IDX_MAX) r_round_idx <= r_round_idx + 1'b1;
        end
        ST_CHECK: if (w_game_end) r_game_winner <= w_leader;
        default: ;
      endcase
    end
  end

  assign bus.p1_card_ready      = w_p1_ready;
  assign bus.p2_card_ready      = w_p2_ready;
  assign bus.cmp_p1_card        = w_p1_card;
  assign bus.cmp_p2_card        = w_p2_card;
  assign bus.round_result       = r_round_result;
  assign bus.round_result_valid = r_round_result_valid;
  assign bus.p1_score           = r_p1_score;
  assign bus.p2_score           = r_p2_score;
  assign bus.round_idx          = r_round_idx;
  assign bus.busy               = w_busy;
  assign bus.game_over          = w_game_over;
  assign bus.game_winner        = r_game_winner;

endmodule
`default_nettype wire

// File: tb/tb_round_controller.sv
`default_nettype none
// Bench for round_controller: directed rounds, a scoring model and a comparator stub.
module tb_round_controller;
  import card_game_pkg::*;

  localparam int CARD_W    = 4;
  localparam int ROUNDS    = 5;
  localparam int WIN_SCORE = 3;
  localparam int SCORE_W   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic force_zero = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   rrv_cnt = 0;
  int   last_rrv_cyc = 0;
  int   n;

  typedef struct {
    logic [1:0] res;
    int p1, p2, idx, c1, c2;
  } exp_t;
  exp_t q[$];
  exp_t cmp_e;

  int         m_p1, m_p2, m_idx;
  logic       m_over;
  logic [1:0] m_win;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  round_controller_if #(.CARD_W(CARD_W), .SCORE_W(SCORE_W)) bus ();

  round_controller #(
    .CARD_W(CARD_W), .ROUNDS(ROUNDS), .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Comparator stand-in; force_zero makes it report "no result".
  assign bus.cmp_result = force_zero ? 2'b00 :
                          (bus.cmp_p1_card > bus.cmp_p2_card) ? 2'b10 :
                          (bus.cmp_p2_card > bus.cmp_p1_card) ? 2'b11 : 2'b01;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.round_result_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_round_result_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        cmp_e = q.pop_front();
        chk("round_result", bus.round_result, cmp_e.res);
        chk("p1_score", bus.p1_score, cmp_e.p1);
        chk("p2_score", bus.p2_score, cmp_e.p2);
        chk("round_idx", bus.round_idx, cmp_e.idx);
        chk("cmp_p1_card", bus.cmp_p1_card, cmp_e.c1);
        chk("cmp_p2_card", bus.cmp_p2_card, cmp_e.c2);
      end
      rrv_cnt++;
      last_rrv_cyc = cyc;
    end
  end

  task automatic model_clear();
    m_p1 = 0; m_p2 = 0; m_idx = 0; m_over = 1'b0; m_win = 2'b00;
    q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_p1_ready"}, bus.p1_card_ready, 0);
    chk({tag, "_p2_ready"}, bus.p2_card_ready, 0);
    chk({tag, "_cmp_p1"}, bus.cmp_p1_card, 0);
    chk({tag, "_cmp_p2"}, bus.cmp_p2_card, 0);
    chk({tag, "_round_result"}, bus.round_result, 0);
    chk({tag, "_rrv"}, bus.round_result_valid, 0);
    chk({tag, "_p1_score"}, bus.p1_score, 0);
    chk({tag, "_p2_score"}, bus.p2_score, 0);
    chk({tag, "_round_idx"}, bus.round_idx, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_game_over"}, bus.game_over, 0);
    chk({tag, "_game_winner"}, bus.game_winner, 0);
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    model_clear();
    @(negedge clk);
    chk("start_p1_score", bus.p1_score, 0);
    chk("start_p2_score", bus.p2_score, 0);
    chk("start_round_idx", bus.round_idx, 0);
    chk("start_round_result", bus.round_result, 0);
    chk("start_game_winner", bus.game_winner, 0);
    chk("start_busy", bus.busy, 1);
    @(posedge clk); #1;
  endtask

  // Offer both cards (player X waits dX cycles first); n = cycle of the later accept.
  task automatic offer(input int c1, input int c2, input int d1, input int d2, output int nacc);
    bit a1 = 0, a2 = 0;
    nacc = -1;
    for (int s = 0; s < 40 && !(a1 && a2); s++) begin
      bus.p1_card_valid = !a1 && (s >= d1);
      bus.p2_card_valid = !a2 && (s >= d2);
      bus.p1_card = CARD_W'(c1);
      bus.p2_card = CARD_W'(c2);
      @(negedge clk);
      if (a1) begin
        chk("p1_ready_after_accept", bus.p1_card_ready, 0);
        chk("p1_held_card", bus.cmp_p1_card, c1);
      end
      if (a2) begin
        chk("p2_ready_after_accept", bus.p2_card_ready, 0);
        chk("p2_held_card", bus.cmp_p2_card, c2);
      end
      if (!a1 && bus.p1_card_valid && bus.p1_card_ready) begin a1 = 1; nacc = cyc; end
      if (!a2 && bus.p2_card_valid && bus.p2_card_ready) begin a2 = 1; nacc = cyc; end
      @(posedge clk); #1;
    end
    bus.p1_card_valid = 1'b0;
    bus.p2_card_valid = 1'b0;
    if (!(a1 && a2)) chk("card_accept_timeout", 0, 1);
  endtask

  // Score the round from the game rules, then check result timing and end-of-round status.
  task automatic finish(input int c1, input int c2, input int nacc);
    exp_t e;
    int   cnt0;
    int   k;
    bit   tiebreak;
`ifdef ROUND_TIEBREAK_EN
    tiebreak = 1;
`else
    tiebreak = 0;
`endif
    e.res = force_zero ? 2'b01 : (c1 > c2) ? 2'b10 : (c2 > c1) ? 2'b11 : 2'b01;
    if (e.res == 2'b10) m_p1++;
    if (e.res == 2'b11) m_p2++;
    m_idx = (m_idx < 15) ? m_idx + 1 : 15;
    m_over = (m_p1 == WIN_SCORE) || (m_p2 == WIN_SCORE) ||
             ((m_idx >= ROUNDS) && !(tiebreak && m_p1 == m_p2));
    m_win = !m_over ? 2'b00 : (m_p1 > m_p2) ? 2'b10 : (m_p2 > m_p1) ? 2'b11 : 2'b01;
    e.p1 = m_p1; e.p2 = m_p2; e.idx = m_idx; e.c1 = c1; e.c2 = c2;
    q.push_back(e);
    cnt0 = rrv_cnt;
    k = 0;
    while (rrv_cnt == cnt0 && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    if (rrv_cnt == cnt0) chk("round_result_valid_timeout", 0, 1);
    else chk("result_latency", last_rrv_cyc - nacc, 2);
    @(negedge clk);
    chk("rrv_one_cycle", bus.round_result_valid, 0);
    chk("game_over", bus.game_over, m_over);
    chk("game_winner", bus.game_winner, m_win);
    chk("busy", bus.busy, !m_over);
    chk("p1_ready_next_round", bus.p1_card_ready, !m_over);
    chk("p2_ready_next_round", bus.p2_card_ready, !m_over);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.p1_card_valid = 1'b0;
    bus.p2_card_valid = 1'b0;
    bus.p1_card = '0;
    bus.p2_card = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;

    // Game 1: simultaneous cards, staggered cards, ignored start, null comparator, abort.
    start_game();
    offer(9, 3, 0, 0, n);
    finish(9, 3, n);
    chk("g1_r1_result_lit", bus.round_result, 2'b10);
    chk("g1_r1_p1_score_lit", bus.p1_score, 1);
    offer(2, 7, 0, 4, n);
    finish(2, 7, n);
    chk("g1_r2_p2_score_lit", bus.p2_score, 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_start_p1", bus.p1_score, m_p1);
    chk("busy_start_p2", bus.p2_score, m_p2);
    chk("busy_start_idx", bus.round_idx, m_idx);
    chk("busy_start_busy", bus.busy, 1);
    @(posedge clk); #1;
    force_zero = 1'b1;
    offer(8, 1, 2, 0, n);
    finish(8, 1, n);
    force_zero = 1'b0;
    chk("g1_null_cmp_draw_lit", bus.round_result, 2'b01);
    offer(4, 4, 0, 0, n);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    model_clear();
    @(posedge clk); #1;

    // Game 2: player 1 sweeps and the game closes early.
    start_game();
    offer(12, 1, 0, 0, n);  finish(12, 1, n);
    offer(5, 4, 3, 1, n);   finish(5, 4, n);
    offer(15, 0, 1, 2, n);  finish(15, 0, n);
    chk("g2_winner_lit", bus.game_winner, 2'b10);
    chk("g2_round_idx_lit", bus.round_idx, 3);
    bus.p1_card_valid = 1'b1;
    bus.p2_card_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_game_p1_ready", bus.p1_card_ready, 0);
      chk("post_game_p2_ready", bus.p2_card_ready, 0);
      chk("post_game_p1_score", bus.p1_score, 3);
    end
    @(posedge clk); #1;
    bus.p1_card_valid = 1'b0;
    bus.p2_card_valid = 1'b0;

    // Game 3: level after regulation.
    start_game();
    offer(6, 2, 0, 0, n);   finish(6, 2, n);
    offer(1, 9, 1, 0, n);   finish(1, 9, n);
    offer(7, 7, 0, 0, n);   finish(7, 7, n);
    offer(10, 3, 0, 2, n);  finish(10, 3, n);
    offer(0, 15, 0, 0, n);  finish(0, 15, n);
`ifdef ROUND_TIEBREAK_EN
    chk("g3_sudden_death_lit", bus.game_over, 0);
    offer(3, 11, 0, 0, n);  finish(3, 11, n);
    chk("g3_winner_lit", bus.game_winner, 2'b11);
    chk("g3_round_idx_lit", bus.round_idx, 6);
`else
    chk("g3_winner_lit", bus.game_winner, 2'b01);
    chk("g3_round_idx_lit", bus.round_idx, 5);
`endif
    chk("g3_over_lit", bus.game_over, 1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
